// File: rtl/vect_pkg.sv
// Shared types for the vector dispatch block: issue FSM states and queue entry layout.
package vect_pkg;

    // Lane width of a queued entry; the dispatcher's DATA_WIDTH must match this.
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssue  = 2'd1,
        StSettle = 2'd2,
        StWait   = 2'd3
    } dispatch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } vq_entry_t;

endpackage

// File: rtl/vect_dispatch_if.sv
// Bus bundle between the scalar core, the dispatcher and the vector core.
// Signal suffixes are from the dispatcher's point of view.
interface vect_dispatch_if #(
    parameter int unsigned DATA_WIDTH = vect_pkg::XLEN
) ();
    // Scalar core -> dispatcher
    logic                  cpu_valid_i;
    logic [DATA_WIDTH-1:0] cpu_instr_i;
    logic [DATA_WIDTH-1:0] cpu_rs1_i;
    logic [DATA_WIDTH-1:0] cpu_rs2_i;
    logic                  cpu_ready_o;
    // Dispatcher -> vector core
    logic [DATA_WIDTH-1:0] vinstr_o;
    logic [DATA_WIDTH-1:0] rs1_o;
    logic [DATA_WIDTH-1:0] rs2_o;
    logic                  vreq_o;
    logic                  vready_i;
    // Vector core scalar result -> scalar core
    logic [DATA_WIDTH-1:0] core_rd_i;
    logic                  core_rd_wr_en_i;
    logic [DATA_WIDTH-1:0] rd_o;
    logic                  rd_valid_o;
    logic                  busy_o;

    modport slave (
        input  cpu_valid_i, cpu_instr_i, cpu_rs1_i, cpu_rs2_i,
        input  vready_i, core_rd_i, core_rd_wr_en_i,
        output cpu_ready_o, vinstr_o, rs1_o, rs2_o, vreq_o,
        output rd_o, rd_valid_o, busy_o
    );

    modport master (
        output cpu_valid_i, cpu_instr_i, cpu_rs1_i, cpu_rs2_i,
        output vready_i, core_rd_i, core_rd_wr_en_i,
        input  cpu_ready_o, vinstr_o, rs1_o, rs2_o, vreq_o,
        input  rd_o, rd_valid_o, busy_o
    );

endinterface

// File: rtl/vect_fifo.sv
// Synchronous FIFO of vector queue entries. Push is refused when full even if a
// pop happens in the same cycle; pop is ignored when empty.
module vect_fifo
    import vect_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  vq_entry_t                    i_wdata,
    input  logic                         i_pop,
    output vq_entry_t                    o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    vq_entry_t       r_mem [DEPTH];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_full    = (r_count == FullCnt);
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rptr];
    assign o_count   = r_count;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/vect_dispatch.sv
// Vector instruction dispatcher: queues {instr, rs1, rs2} from the scalar core and
// issues them one at a time to the vector core, and forwards scalar results back.
module vect_dispatch
    import vect_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned DEPTH      = 4
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    vect_dispatch_if.slave  bus
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    dispatch_state_t       r_state;
    logic                  r_vreq;
    logic [DATA_WIDTH-1:0] r_vinstr;
    logic [DATA_WIDTH-1:0] r_rs1;
    logic [DATA_WIDTH-1:0] r_rs2;
    logic [DATA_WIDTH-1:0] r_rd;
    logic                  r_rd_valid;

    vq_entry_t             w_wentry;
    vq_entry_t             w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [CntW-1:0]       w_count;
    logic                  w_pop;

    assign w_wentry = '{instr: bus.cpu_instr_i, rs1: bus.cpu_rs1_i, rs2: bus.cpu_rs2_i};
    assign w_pop    = (r_state == StIdle) && !w_empty && bus.vready_i;

    vect_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (resetn_i),
        .i_push  (bus.cpu_valid_i),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Issue FSM with registered strobe and operand outputs. SETTLE exists because the
    // vector core's ready only reflects the new instruction one cycle after vreq.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state  <= StIdle;
            r_vreq   <= 1'b0;
            r_vinstr <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
        end else begin
            r_vreq <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_state  <= StIssue;
                        r_vreq   <= 1'b1;
                        r_vinstr <= w_head.instr;
                        r_rs1    <= w_head.rs1;
                        r_rs2    <= w_head.rs2;
                    end
                end
                StIssue:  r_state <= StSettle;
                StSettle: r_state <= StWait;
                StWait: begin
                    if (bus.vready_i) begin
                        r_state <= StIdle;
                    end
                end
                default:  r_state <= StIdle;
            endcase
        end
    end

    // Scalar result forwarding: one-cycle strobe per incoming result.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_rd       <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.core_rd_wr_en_i;
            if (bus.core_rd_wr_en_i) begin
                r_rd <= bus.core_rd_i;
            end
        end
    end

    assign bus.cpu_ready_o = !w_full;
    assign bus.vreq_o      = r_vreq;
    assign bus.vinstr_o    = r_vinstr;
    assign bus.rs1_o       = r_rs1;
    assign bus.rs2_o       = r_rs2;
    assign bus.rd_o        = r_rd;
    assign bus.rd_valid_o  = r_rd_valid;
    assign bus.busy_o      = (w_count != '0) || (r_state != StIdle);

endmodule

// File: tb/tb_vect_dispatch.sv
// Self-checking bench for vect_dispatch: directed scenarios plus a randomized run
// checked against a queue-based behavioural model.
module tb_vect_dispatch;
    import vect_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    vect_dispatch_if #(.DATA_WIDTH(DW)) bus ();

    vect_dispatch #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_valid_i     = 1'b0;
        bus.cpu_instr_i     = '0;
        bus.cpu_rs1_i       = '0;
        bus.cpu_rs2_i       = '0;
        bus.vready_i        = 1'b0;
        bus.core_rd_i       = '0;
        bus.core_rd_wr_en_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        n_cmp++;
        if (bus.cpu_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b want 1", bus.cpu_ready_o);
        end
        n_cmp++;
        if ({bus.vreq_o, bus.rd_valid_o, bus.busy_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 000",
                               {bus.vreq_o, bus.rd_valid_o, bus.busy_o});
        end
        n_cmp++;
        if ({bus.vinstr_o, bus.rs1_o, bus.rs2_o, bus.rd_o} !== 128'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0",
                               {bus.vinstr_o, bus.rs1_o, bus.rs2_o, bus.rd_o});
        end
        resetn = 1'b1;
    endtask

    task automatic test_single_issue();
        do_reset();
        bus.vready_i    = 1'b1;
        bus.cpu_valid_i = 1'b1;
        bus.cpu_instr_i = 32'h0020_8057;
        bus.cpu_rs1_i   = 32'd5;
        bus.cpu_rs2_i   = 32'd0;
        tick();
        bus.cpu_valid_i = 1'b0;
        n_cmp++;
        if (bus.vreq_o !== 1'b0) begin
            n_fail++; $display("FAIL single_cycle0_vreq: got %b want 0", bus.vreq_o);
        end
        n_cmp++;
        if (bus.busy_o !== 1'b1) begin
            n_fail++; $display("FAIL single_busy: got %b want 1", bus.busy_o);
        end
        tick();
        n_cmp++;
        if (bus.vreq_o !== 1'b1) begin
            n_fail++; $display("FAIL single_vreq: got %b want 1", bus.vreq_o);
        end
        n_cmp++;
        if (bus.vinstr_o !== 32'h0020_8057 || bus.rs1_o !== 32'd5) begin
            n_fail++; $display("FAIL single_data: got %h/%h want 00208057/00000005",
                               bus.vinstr_o, bus.rs1_o);
        end
        tick();
        n_cmp++;
        if (bus.vreq_o !== 1'b0 || bus.vinstr_o !== 32'h0020_8057) begin
            n_fail++; $display("FAIL single_hold: got vreq %b instr %h want 0/00208057",
                               bus.vreq_o, bus.vinstr_o);
        end
        tick();
        tick();
        tick();
        n_cmp++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL single_idle_busy: got %b want 0", bus.busy_o);
        end
    endtask

    task automatic test_fill();
        int accepted = 0;
        int vreq_seen = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.cpu_valid_i = 1'b1;
            bus.cpu_instr_i = 32'h100 + i;
            bus.cpu_rs1_i   = i;
            bus.cpu_rs2_i   = ~i;
            if (bus.cpu_ready_o === 1'b1) accepted++;
            tick();
            if (bus.vreq_o === 1'b1) vreq_seen++;
            if (i == 3) begin
                n_cmp++;
                if (bus.cpu_ready_o !== 1'b0) begin
                    n_fail++; $display("FAIL fill_ready_after_4th: got %b want 0",
                                       bus.cpu_ready_o);
                end
            end
        end
        bus.cpu_valid_i = 1'b0;
        n_cmp++;
        if (accepted != 4) begin
            n_fail++; $display("FAIL fill_accepted: got %0d want 4", accepted);
        end
        n_cmp++;
        if (bus.busy_o !== 1'b1 || bus.cpu_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL fill_status: got busy %b ready %b want 1/0",
                               bus.busy_o, bus.cpu_ready_o);
        end
        n_cmp++;
        if (vreq_seen != 0) begin
            n_fail++; $display("FAIL fill_no_issue: got %0d pulses want 0", vreq_seen);
        end
    endtask

    task automatic test_order_backpressure();
        logic [31:0] exp_instr [3];
        logic [31:0] last = '0;
        int   n_issue = 0;
        int   hold = 0;
        logic prev_vreq = 1'b0;
        exp_instr[0] = 32'hAAAA_0001;
        exp_instr[1] = 32'hBBBB_0002;
        exp_instr[2] = 32'hCCCC_0003;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.cpu_valid_i = 1'b1;
            bus.cpu_instr_i = exp_instr[i];
            bus.cpu_rs1_i   = i;
            tick();
        end
        bus.cpu_valid_i = 1'b0;
        bus.vready_i    = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            tick();
            if (bus.vreq_o === 1'b1) begin
                n_cmp++;
                if (prev_vreq !== 1'b0) begin
                    n_fail++; $display("FAIL order_pulse_width: got 2-cycle vreq want 1");
                end
                if (n_issue < 3) begin
                    n_cmp++;
                    if (bus.vinstr_o !== exp_instr[n_issue]) begin
                        n_fail++; $display("FAIL order_instr: got %h want %h",
                                           bus.vinstr_o, exp_instr[n_issue]);
                    end
                end
                n_issue++;
                last = bus.vinstr_o;
                hold = 12;
            end else if (n_issue > 0) begin
                n_cmp++;
                if (bus.vinstr_o !== last) begin
                    n_fail++; $display("FAIL order_hold: got %h want %h", bus.vinstr_o, last);
                end
            end
            prev_vreq = bus.vreq_o;
            if (hold > 0) begin
                bus.vready_i = 1'b0;
                hold--;
            end else begin
                bus.vready_i = 1'b1;
            end
        end
        n_cmp++;
        if (n_issue != 3) begin
            n_fail++; $display("FAIL order_count: got %0d issues want 3", n_issue);
        end
    endtask

    task automatic test_concurrent();
        logic [31:0] e [6];
        logic [31:0] exp_drain [4];
        bit found = 0;
        int n = 0;
        for (int i = 0; i < 6; i++) e[i] = 32'hC0DE_0000 + i;
        for (int i = 0; i < 4; i++) exp_drain[i] = e[i + 2];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.cpu_valid_i = 1'b1;
            bus.cpu_instr_i = e[i];
            bus.cpu_rs1_i   = e[i] ^ 32'h5555_5555;
            tick();
        end
        bus.cpu_valid_i = 1'b0;
        bus.vready_i    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.vreq_o === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_cmp++;
        if (!found || bus.vinstr_o !== e[0]) begin
            n_fail++; $display("FAIL conc_first: got found %0d instr %h want 1/%h",
                               found, bus.vinstr_o, e[0]);
        end
        tick();
        tick();
        tick();
        // FSM is back in idle here; push and pop land on the same edge with two queued.
        bus.cpu_valid_i = 1'b1;
        bus.cpu_instr_i = e[3];
        bus.cpu_rs1_i   = e[3] ^ 32'h5555_5555;
        tick();
        bus.cpu_valid_i = 1'b0;
        bus.vready_i    = 1'b0;
        n_cmp++;
        if (bus.vreq_o !== 1'b1 || bus.vinstr_o !== e[1]) begin
            n_fail++; $display("FAIL conc_pop: got vreq %b instr %h want 1/%h",
                               bus.vreq_o, bus.vinstr_o, e[1]);
        end
        for (int i = 4; i < 6; i++) begin
            n_cmp++;
            if (bus.cpu_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL conc_ready_before_push: got %b want 1",
                                   bus.cpu_ready_o);
            end
            bus.cpu_valid_i = 1'b1;
            bus.cpu_instr_i = e[i];
            bus.cpu_rs1_i   = e[i] ^ 32'h5555_5555;
            tick();
        end
        bus.cpu_valid_i = 1'b0;
        n_cmp++;
        if (bus.cpu_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL conc_count_kept: got ready %b want 0", bus.cpu_ready_o);
        end
        bus.vready_i = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus.vreq_o === 1'b1) begin
                if (n < 4) begin
                    n_cmp++;
                    if (bus.vinstr_o !== exp_drain[n] ||
                        bus.rs1_o !== (exp_drain[n] ^ 32'h5555_5555)) begin
                        n_fail++; $display("FAIL conc_drain: got %h/%h want %h/%h",
                                           bus.vinstr_o, bus.rs1_o, exp_drain[n],
                                           exp_drain[n] ^ 32'h5555_5555);
                    end
                end
                n++;
            end
        end
        n_cmp++;
        if (n != 4) begin
            n_fail++; $display("FAIL conc_drain_count: got %0d want 4", n);
        end
    endtask

    task automatic test_scalar_result();
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        bus.core_rd_wr_en_i = 1'b1;
        bus.core_rd_i       = 32'hDEAD_BEEF;
        tick();
        bus.core_rd_wr_en_i = 1'b0;
        n_cmp++;
        if (bus.rd_valid_o !== 1'b1 || bus.rd_o !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd_capture: got %b/%h want 1/deadbeef",
                               bus.rd_valid_o, bus.rd_o);
        end
        tick();
        n_cmp++;
        if (bus.rd_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_one_cycle: got %b want 0", bus.rd_valid_o);
        end
        bus.core_rd_wr_en_i = 1'b1;
        bus.core_rd_i       = 32'h1111_2222;
        tick();
        bus.core_rd_i       = 32'h3333_4444;
        n_cmp++;
        if (bus.rd_valid_o !== 1'b1 || bus.rd_o !== 32'h1111_2222) begin
            n_fail++; $display("FAIL rd_b2b_first: got %b/%h want 1/11112222",
                               bus.rd_valid_o, bus.rd_o);
        end
        tick();
        bus.core_rd_wr_en_i = 1'b0;
        n_cmp++;
        if (bus.rd_valid_o !== 1'b1 || bus.rd_o !== 32'h3333_4444) begin
            n_fail++; $display("FAIL rd_b2b_second: got %b/%h want 1/33334444",
                               bus.rd_valid_o, bus.rd_o);
        end
        tick();
        n_cmp++;
        if (bus.rd_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_b2b_end: got %b want 0", bus.rd_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.cpu_valid_i = 1'b1;
            bus.cpu_instr_i = 32'hF00D_0000 + i;
            bus.cpu_rs1_i   = 32'h77;
            tick();
        end
        bus.cpu_valid_i = 1'b0;
        bus.vready_i    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.vreq_o === 1'b1) begin
                found = 1;
                break;
            end
        end
        bus.vready_i        = 1'b0;
        bus.core_rd_wr_en_i = 1'b1;
        bus.core_rd_i       = 32'h5A5A_5A5A;
        tick();
        bus.core_rd_wr_en_i = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (!found || bus.busy_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_setup: got found %0d busy %b want 1/1",
                               found, bus.busy_o);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (bus.cpu_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_ready: got %b want 1", bus.cpu_ready_o);
        end
        n_cmp++;
        if ({bus.vreq_o, bus.rd_valid_o, bus.busy_o} !== 3'b000 ||
            {bus.vinstr_o, bus.rs1_o, bus.rs2_o, bus.rd_o} !== 128'd0) begin
            n_fail++; $display("FAIL rstmid_outputs: got %b %h want 0",
                               {bus.vreq_o, bus.rd_valid_o, bus.busy_o},
                               {bus.vinstr_o, bus.rs1_o, bus.rs2_o, bus.rd_o});
        end
        tick();
        tick();
        resetn       = 1'b1;
        bus.vready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.vreq_o === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || bus.busy_o !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_issue: got %0d pulses busy %b want 0/0",
                               pulses, bus.busy_o);
        end
    endtask

    // Randomized run against a model: a queue of pending entries plus the time since
    // the last issue. After an issue the core is unavailable for two cycles, then
    // frees up on the first edge that sees vready_i high.
    task automatic test_random();
        vq_entry_t   mq [$];
        vq_entry_t   m_out = '0;
        vq_entry_t   e;
        bit          m_idle = 1;
        int          m_age = 0;
        bit          m_vreq = 0;
        bit          m_rdv = 0;
        logic [31:0] m_rd = '0;
        bit          push;
        bit          pop;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            n_cmp++;
            if (bus.cpu_ready_o !== (mq.size() != DEPTH) || bus.vreq_o !== m_vreq ||
                bus.busy_o !== (mq.size() != 0 || !m_idle)) begin
                n_fail++; $display("FAIL rand_ctrl c=%0d: got rdy %b vreq %b busy %b want %b %b %b",
                                   c, bus.cpu_ready_o, bus.vreq_o, bus.busy_o,
                                   mq.size() != DEPTH, m_vreq, mq.size() != 0 || !m_idle);
            end
            n_cmp++;
            if ({bus.vinstr_o, bus.rs1_o, bus.rs2_o} !== m_out) begin
                n_fail++; $display("FAIL rand_data c=%0d: got %h want %h", c,
                                   {bus.vinstr_o, bus.rs1_o, bus.rs2_o}, m_out);
            end
            n_cmp++;
            if (bus.rd_valid_o !== m_rdv || bus.rd_o !== m_rd) begin
                n_fail++; $display("FAIL rand_rd c=%0d: got %b/%h want %b/%h", c,
                                   bus.rd_valid_o, bus.rd_o, m_rdv, m_rd);
            end
            bus.cpu_valid_i     = ($urandom_range(0, 99) < 60);
            bus.cpu_instr_i     = $urandom();
            bus.cpu_rs1_i       = $urandom();
            bus.cpu_rs2_i       = $urandom();
            bus.vready_i        = ($urandom_range(0, 99) < 70);
            bus.core_rd_wr_en_i = ($urandom_range(0, 99) < 30);
            bus.core_rd_i       = $urandom();
            push = bus.cpu_valid_i && (mq.size() != DEPTH);
            pop  = m_idle && (mq.size() != 0) && bus.vready_i;
            e    = '{instr: bus.cpu_instr_i, rs1: bus.cpu_rs1_i, rs2: bus.cpu_rs2_i};
            if (pop) begin
                m_out  = mq.pop_front();
                m_vreq = 1;
                m_idle = 0;
                m_age  = 0;
            end else begin
                m_vreq = 0;
                if (!m_idle) begin
                    if (m_age >= 2 && bus.vready_i) m_idle = 1;
                    else if (m_age < 2) m_age++;
                end
            end
            if (push) mq.push_back(e);
            m_rdv = bus.core_rd_wr_en_i;
            if (bus.core_rd_wr_en_i) m_rd = bus.core_rd_i;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_issue();
        test_fill();
        test_order_backpressure();
        test_concurrent();
        test_scalar_result();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vect_dispatch.md
VECT_DISPATCH -- requirements
Module: vect_dispatch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning instruction and scalar operand width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning number of instruction queue entries (power of two, at least 2).
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port resetn_i, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port cpu_valid_i, input, 1, scalar core offers a vector instruction.
REQ-006 The block SHALL have port cpu_instr_i, input, DATA_WIDTH, vector instruction word.
REQ-007 The block SHALL have port cpu_rs1_i, input, DATA_WIDTH, scalar rs1 value.
REQ-008 The block SHALL have port cpu_rs2_i, input, DATA_WIDTH, scalar rs2 value.
REQ-009 The block SHALL have port cpu_ready_o, output, 1, queue can accept an entry.
REQ-010 The block SHALL have port vinstr_o, output, DATA_WIDTH, instruction to the vector core.
REQ-011 The block SHALL have port rs1_o, output, DATA_WIDTH, rs1 to the vector core.
REQ-012 The block SHALL have port rs2_o, output, DATA_WIDTH, rs2 to the vector core.
REQ-013 The block SHALL have port vreq_o, output, 1, one-cycle issue strobe to the vector core.
REQ-014 The block SHALL have port vready_i, input, 1, vector core idle/ready.
REQ-015 The block SHALL have port core_rd_i, input, DATA_WIDTH, scalar result from the vector core.
REQ-016 The block SHALL have port core_rd_wr_en_i, input, 1, scalar result valid.
REQ-017 The block SHALL have port rd_o, output, DATA_WIDTH, registered scalar result to the CPU.
REQ-018 The block SHALL have port rd_valid_o, output, 1, one-cycle strobe qualifying rd_o.
REQ-019 The block SHALL have port busy_o, output, 1, queue non-empty or issue FSM not IDLE.

Function
REQ-020 A push SHALL occur on a rising edge where cpu_valid_i and cpu_ready_o are both 1; the entry {instr, rs1, rs2} SHALL be stored in FIFO order.
REQ-021 cpu_ready_o SHALL equal (count != DEPTH); there SHALL be no full-bypass, so when full, a push is refused even if a pop occurs in the same cycle.
REQ-022 Simultaneous push and pop when not full SHALL leave count unchanged and preserve order.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH+1) bits.
REQ-024 The issue FSM SHALL have states IDLE, ISSUE, SETTLE, WAIT.
REQ-025 IDLE SHALL go to ISSUE when count != 0 and vready_i = 1; otherwise it SHALL stay in IDLE.
REQ-026 On IDLE->ISSUE the head entry SHALL be popped into the output registers vinstr_o/rs1_o/rs2_o.
REQ-027 In ISSUE, vreq_o SHALL be 1 for exactly that cycle, and the FSM SHALL go to SETTLE unconditionally.
REQ-028 SETTLE SHALL last one cycle and ignore vready_i, because the core's ready reflects the new instruction only one cycle after vreq.
REQ-029 WAIT SHALL go to IDLE on the first cycle vready_i = 1.
REQ-030 vinstr_o/rs1_o/rs2_o SHALL hold stable from ISSUE until the next pop.
REQ-031 Latency: an entry pushed at edge N into an empty queue with vready_i = 1 SHALL produce vreq_o = 1 in cycle N+1; the minimum interval between successive vreq_o strobes SHALL be 4 cycles.
REQ-032 On a cycle with core_rd_wr_en_i = 1, rd_o SHALL capture core_rd_i and rd_valid_o SHALL be 1 in the following cycle only; back-to-back strobes SHALL each be forwarded.
REQ-033 busy_o SHALL be combinational: (count != 0) or (state != IDLE).

Reset
REQ-034 While resetn_i = 0, count, pointers and all outputs SHALL be 0 and state SHALL be IDLE; cpu_ready_o SHALL be 1.
REQ-035 Reset asserted mid-operation SHALL discard all queued and in-flight entries, with no vreq_o pulse after release until a new push.

Structure
REQ-036 The dispatch_state_t enum and the vq_entry_t packed struct {instr, rs1, rs2} SHALL be placed in vect_pkg.
REQ-037 The queue SHALL be a sub-module vect_fifo, a parameterised synchronous FIFO with push/pop/full/empty/count.

Verification
REQ-038 Single issue: push instr 0x0020_8057 with rs1 = 5 at cycle 0 and vready_i = 1 -> vreq_o at cycle 1, vinstr_o = 0x0020_8057, rs1_o = 5.
REQ-039 Fill: vready_i = 0, push 5 entries -> 4 are accepted, cpu_ready_o = 0 after the 4th, busy_o = 1.
REQ-040 Order/backpressure: queue holding A, B, C, with vready_i held low for 10 cycles in each WAIT -> vreq_o issues A, B, C in order, each exactly one cycle wide.
REQ-041 Concurrent push/pop at count = 2 -> count stays 2; the wrapped-pointer entry is read back correctly.
REQ-042 Scalar result: core_rd_wr_en_i = 1 with core_rd_i = 0xDEAD_BEEF at cycle 7 -> rd_valid_o = 1 and rd_o = 0xDEAD_BEEF at cycle 8 only.
REQ-043 Reset asserted in WAIT with 3 entries queued -> all outputs 0, cpu_ready_o = 1, and no vreq_o pulse after release.
